// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller.
// Contents: states, opcodes, ALU op codes and datapath mux selects.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_BRANCH = 4'd11,
    S_JUMP   = 4'd12
  } state_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_J     = 6'h02;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that own the memory port and may stall on mem_ready.
  function automatic logic is_mem_state(state_e s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Controller <-> datapath bundle: opcode and memory handshake in, control strobes and status out.
interface mips_multicycle_control_if #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 2
);
  logic [OPCODE_W-1:0] OPCODE;
  logic                mem_ready;
  logic                mem_req;
  logic                memread;
  logic                memwrite;
  logic                iord;
  logic                irwrite;
  logic                pcwrite;
  logic                pcwritecond;
  logic [1:0]          pcsource;
  logic                alusrca;
  logic [1:0]          alusrcb;
  logic [ALUOP_W-1:0]  aluop;
  logic                regdist;
  logic                memtoreg;
  logic                regwrite;
  logic                illegal;
  logic                timeout_err;
  logic [3:0]          state_o;

  modport master (
    input  OPCODE, mem_ready,
    output mem_req, memread, memwrite, iord, irwrite, pcwrite, pcwritecond,
           pcsource, alusrca, alusrcb, aluop, regdist, memtoreg, regwrite,
           illegal, timeout_err, state_o
  );

  modport slave (
    output OPCODE, mem_ready,
    input  mem_req, memread, memwrite, iord, irwrite, pcwrite, pcwritecond,
           pcsource, alusrca, alusrcb, aluop, regdist, memtoreg, regwrite,
           illegal, timeout_err, state_o
  );
endinterface

// File: rtl/mips_mem_wait_timer.sv
// Saturating wait counter for memory stalls; expire fires on the TIMEOUT-th consecutive wait cycle.
module mips_mem_wait_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  output logic expire
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] LIMIT = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  logic [CNT_W-1:0] cnt;

  // The wait that would bring the count to TIMEOUT is the one that gives up.
  assign expire = waiting && (TIMEOUT != 0) && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!waiting || expire) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences each instruction and drives the datapath strobes.
// state | meaning: IDLE post-reset | FETCH read IR, PC+4 | DECODE reg read, branch target
//   MEMADR ld/st address | MEMRD load read | MEMWB load writeback | MEMWR store write
//   EXEC R-type ALU | RWB R-type writeback | ADDIEX imm add | ADDIWB imm writeback
//   BRANCH beq compare | JUMP pc <- target
module mips_multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int                  OPCODE_W = 6,
  parameter int                  ALUOP_W  = 2,
  parameter int                  TIMEOUT  = 15,
  parameter logic [OPCODE_W-1:0] OP_RTYPE = OPC_RTYPE,
  parameter logic [OPCODE_W-1:0] OP_ADDI  = OPC_ADDI,
  parameter logic [OPCODE_W-1:0] OP_LW    = OPC_LW,
  parameter logic [OPCODE_W-1:0] OP_SW    = OPC_SW,
  parameter logic [OPCODE_W-1:0] OP_BEQ   = OPC_BEQ,
  parameter logic [OPCODE_W-1:0] OP_J     = OPC_J
) (
  input logic                       clk,
  input logic                       rst_n,
  mips_multicycle_control_if.master bus
);
  state_e              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic                illegal_q, illegal_set, timeout_q, expire;
  logic [ALUOP_W-1:0]  aluop_s;

  mips_mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait (
    .clk    (clk),
    .rst_n  (rst_n),
    .waiting(is_mem_state(state_q) && !bus.mem_ready),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // MEMADR needs the opcode after IR may have moved on, so keep our own copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == S_DECODE) op_q <= bus.OPCODE;
      if (illegal_set)         illegal_q <= 1'b1;
      if (expire)              timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    illegal_set = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        if (bus.OPCODE == OP_LW || bus.OPCODE == OP_SW) state_d = S_MEMADR;
        else if (bus.OPCODE == OP_RTYPE)                state_d = S_EXEC;
        else if (bus.OPCODE == OP_ADDI)                 state_d = S_ADDIEX;
        else if (bus.OPCODE == OP_BEQ)                  state_d = S_BRANCH;
        else if (bus.OPCODE == OP_J)                    state_d = S_JUMP;
        else begin
          state_d     = S_FETCH;
          illegal_set = 1'b1;
        end
      end
      S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (bus.mem_ready)  state_d = S_MEMWB;
        else if (expire)    state_d = S_FETCH;
      end
      S_MEMWR:  if (bus.mem_ready || expire) state_d = S_FETCH;
      S_EXEC:   state_d = S_RWB;
      S_ADDIEX: state_d = S_ADDIWB;
      S_MEMWB, S_RWB, S_ADDIWB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req     = 1'b0;
    bus.memread     = 1'b0;
    bus.memwrite    = 1'b0;
    bus.iord        = 1'b0;
    bus.irwrite     = 1'b0;
    bus.pcwrite     = 1'b0;
    bus.pcwritecond = 1'b0;
    bus.pcsource    = PCSRC_ALU;
    bus.alusrca     = 1'b0;
    bus.alusrcb     = SRCB_B;
    aluop_s         = ALUOP_W'(ALUOP_ADD);
    bus.regdist     = 1'b0;
    bus.memtoreg    = 1'b0;
    bus.regwrite    = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.mem_req = 1'b1;
        bus.memread = 1'b1;
        bus.irwrite = bus.mem_ready;
        bus.pcwrite = bus.mem_ready;
        bus.alusrcb = SRCB_FOUR;
      end
      S_DECODE: bus.alusrcb = SRCB_IMMSH2;
      S_MEMADR, S_ADDIEX: begin
        bus.alusrca = 1'b1;
        bus.alusrcb = SRCB_IMM;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.memread = 1'b1;
        bus.iord    = 1'b1;
      end
      S_MEMWB: begin
        bus.memtoreg = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_MEMWR: begin
        bus.mem_req  = 1'b1;
        bus.memwrite = 1'b1;
        bus.iord     = 1'b1;
      end
      S_EXEC: begin
        bus.alusrca = 1'b1;
        aluop_s     = ALUOP_W'(ALUOP_FUNCT);
      end
      S_RWB: begin
        bus.regdist  = 1'b1;
        bus.regwrite = 1'b1;
      end
      S_ADDIWB: bus.regwrite = 1'b1;
      S_BRANCH: begin
        bus.alusrca     = 1'b1;
        aluop_s         = ALUOP_W'(ALUOP_SUB);
        bus.pcwritecond = 1'b1;
        bus.pcsource    = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        bus.pcwrite  = 1'b1;
        bus.pcsource = PCSRC_JUMP;
      end
      default: ;
    endcase
  end

  assign bus.aluop       = aluop_s;
  assign bus.illegal     = illegal_q;
  assign bus.timeout_err = timeout_q;
  assign bus.state_o     = state_q;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-cycle expected state, strobes and flags.
module tb_mips_multicycle_control;
  import mips_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_multicycle_control_if #(.OPCODE_W(6), .ALUOP_W(2)) bus ();

  mips_multicycle_control #(.TIMEOUT(15)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    state_e     st;
    logic       rdy;
    logic [5:0] op;
    logic       ill;
    logic       tmo;
  } cyc_t;

  cyc_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_cyc = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, n_cyc, obs, exp);
    end
  endtask

  // {mem_req,memread,memwrite,iord,irwrite,pcwrite,pcwritecond,pcsource,alusrca,alusrcb,aluop,regdist,memtoreg,regwrite}
  function automatic logic [17:0] exp_strobes(state_e st, logic rdy);
    logic mreq, mrd, mwr, iord, irw, pcw, pcwc, asa, rd, m2r, rw;
    logic [1:0] pcs, asb, aop;
    {mreq, mrd, mwr, iord, irw, pcw, pcwc, asa, rd, m2r, rw} = '0;
    pcs = 2'b00; asb = 2'b00; aop = 2'b00;
    case (st)
      S_FETCH:  begin mreq = 1; mrd = 1; irw = rdy; pcw = rdy; asb = 2'b01; end
      S_DECODE: asb = 2'b11;
      S_MEMADR: begin asa = 1; asb = 2'b10; end
      S_MEMRD:  begin mreq = 1; mrd = 1; iord = 1; end
      S_MEMWB:  begin m2r = 1; rw = 1; end
      S_MEMWR:  begin mreq = 1; mwr = 1; iord = 1; end
      S_EXEC:   begin asa = 1; aop = 2'b10; end
      S_RWB:    begin rd = 1; rw = 1; end
      S_ADDIEX: begin asa = 1; asb = 2'b10; end
      S_ADDIWB: rw = 1;
      S_BRANCH: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      S_JUMP:   begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {mreq, mrd, mwr, iord, irw, pcw, pcwc, pcs, asa, asb, aop, rd, m2r, rw};
  endfunction

  function automatic logic [17:0] obs_strobes();
    return {bus.mem_req, bus.memread, bus.memwrite, bus.iord, bus.irwrite, bus.pcwrite,
            bus.pcwritecond, bus.pcsource, bus.alusrca, bus.alusrcb, bus.aluop,
            bus.regdist, bus.memtoreg, bus.regwrite};
  endfunction

  task automatic push(state_e st, logic rdy, logic [5:0] op, logic ill, logic tmo);
    cyc_t c;
    c.st = st; c.rdy = rdy; c.op = op; c.ill = ill; c.tmo = tmo;
    sbq.push_back(c);
  endtask

  // Zero-wait instruction: expected per-cycle state sequence.
  task automatic push_instr(logic [5:0] op, logic ill, logic tmo);
    push(S_FETCH, 1'b1, op, ill, tmo);
    push(S_DECODE, 1'b1, op, ill, tmo);
    case (op)
      6'h23: begin
        push(S_MEMADR, 1'b1, op, ill, tmo);
        push(S_MEMRD, 1'b1, op, ill, tmo);
        push(S_MEMWB, 1'b1, op, ill, tmo);
      end
      6'h2B: begin
        push(S_MEMADR, 1'b1, op, ill, tmo);
        push(S_MEMWR, 1'b1, op, ill, tmo);
      end
      6'h00: begin
        push(S_EXEC, 1'b1, op, ill, tmo);
        push(S_RWB, 1'b1, op, ill, tmo);
      end
      6'h08: begin
        push(S_ADDIEX, 1'b1, op, ill, tmo);
        push(S_ADDIWB, 1'b1, op, ill, tmo);
      end
      6'h04: push(S_BRANCH, 1'b1, op, ill, tmo);
      6'h02: push(S_JUMP, 1'b1, op, ill, tmo);
      default: ;
    endcase
  endtask

  // Called at a falling edge: drive the cycle's inputs, compare, advance one cycle.
  task automatic run_queue();
    cyc_t c;
    while (sbq.size() > 0) begin
      c = sbq.pop_front();
      bus.OPCODE    = c.op;
      bus.mem_ready = c.rdy;
      #1;
      check("state", 32'(bus.state_o), 32'(c.st));
      check("strobes", 32'(obs_strobes()), 32'(exp_strobes(c.st, c.rdy)));
      check("illegal", 32'(bus.illegal), 32'(c.ill));
      check("timeout_err", 32'(bus.timeout_err), 32'(c.tmo));
      n_cyc++;
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check({tag, "_state"}, 32'(bus.state_o), 32'(S_IDLE));
    check({tag, "_strobes"}, 32'(obs_strobes()), 32'(18'h0));
    check({tag, "_illegal"}, 32'(bus.illegal), 32'(1'b0));
    check({tag, "_timeout"}, 32'(bus.timeout_err), 32'(1'b0));
  endtask

  initial begin
    bus.OPCODE    = 6'h00;
    bus.mem_ready = 1'b0;
    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    push(S_IDLE, 1'b0, 6'h00, 1'b0, 1'b0);
    push_instr(6'h23, 1'b0, 1'b0);
    push_instr(6'h00, 1'b0, 1'b0);
    push_instr(6'h04, 1'b0, 1'b0);
    push_instr(6'h02, 1'b0, 1'b0);

    // SW stalled three cycles in MEMWR: four memwrite cycles, well under TIMEOUT.
    push(S_FETCH, 1'b1, 6'h2B, 1'b0, 1'b0);
    push(S_DECODE, 1'b1, 6'h2B, 1'b0, 1'b0);
    push(S_MEMADR, 1'b1, 6'h2B, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) push(S_MEMWR, 1'b0, 6'h2B, 1'b0, 1'b0);
    push(S_MEMWR, 1'b1, 6'h2B, 1'b0, 1'b0);

    // Fetch never answered: 15 wait cycles, then the flag and a fresh FETCH.
    for (int i = 0; i < 15; i++) push(S_FETCH, 1'b0, 6'h3F, 1'b0, 1'b0);

    push_instr(6'h3F, 1'b0, 1'b1);
    push_instr(6'h08, 1'b1, 1'b1);

    push(S_FETCH, 1'b1, 6'h23, 1'b1, 1'b1);
    push(S_DECODE, 1'b1, 6'h23, 1'b1, 1'b1);
    push(S_MEMADR, 1'b1, 6'h23, 1'b1, 1'b1);
    push(S_MEMRD, 1'b0, 6'h23, 1'b1, 1'b1);
    push(S_MEMRD, 1'b0, 6'h23, 1'b1, 1'b1);
    run_queue();

    // Still in MEMRD; memory answers but reset lands first.
    bus.mem_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check("rst_hold_state", 32'(bus.state_o), 32'(S_IDLE));
    check("rst_hold_regwrite", 32'(bus.regwrite), 32'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    push(S_IDLE, 1'b1, 6'h08, 1'b0, 1'b0);
    push_instr(6'h08, 1'b0, 1'b0);
    push(S_FETCH, 1'b0, 6'h00, 1'b0, 1'b0);
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle main decoder.
- Sequences each MIPS instruction through fetch, decode, execute, memory and writeback states using a registered FSM.
- Drives the datapath control strobes (PC, IR, memory, register file, ALU muxes and ALU op) from the current state.
- Stalls on a memory ready handshake, with a parametrised timeout; flags illegal opcodes and memory timeouts.

Parameters:
- OPCODE_W, 6, opcode field width.
- ALUOP_W, 2, width of aluop to the ALU control block.
- TIMEOUT, 15, max cycles to wait on mem_ready before the error flag; 0 disables the timeout.
- OP_RTYPE, 6'h00, R-type opcode.
- OP_ADDI, 6'h08, ADDI opcode.
- OP_LW, 6'h23, LW opcode.
- OP_SW, 6'h2B, SW opcode.
- OP_BEQ, 6'h04, BEQ opcode.
- OP_J, 6'h02, J opcode.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- OPCODE  in  OPCODE_W  IR[31:26]; sampled only in DECODE.
- mem_ready  in  1  memory has completed the current request this cycle.
- mem_req  out  1  memory access in progress.
- memread  out  1  memory read.
- memwrite  out  1  memory write.
- iord  out  1  0 = PC address, 1 = ALUOut address.
- irwrite  out  1  load IR.
- pcwrite  out  1  unconditional PC load.
- pcwritecond  out  1  PC load if ALU zero.
- pcsource  out  2  00 ALU, 01 ALUOut, 10 jump target.
- alusrca  out  1  0 = PC, 1 = A.
- alusrcb  out  2  00 B, 01 const 4, 10 sign-ext imm, 11 sign-ext imm<<2.
- aluop  out  ALUOP_W  00 add, 01 sub, 10 funct-decoded.
- regdist  out  1  1 = rd, 0 = rt.
- memtoreg  out  1  1 = MDR, 0 = ALUOut.
- regwrite  out  1  register file write.
- illegal  out  1  sticky, unsupported opcode seen.
- timeout_err  out  1  sticky, memory wait exceeded TIMEOUT.
- state_o  out  4  current state encoding, for debug.

Behaviour:
- Reset: state = IDLE, wait counter = 0, illegal = 0, timeout_err = 0. Every strobe output is 0 in IDLE.
- IDLE always moves to FETCH on the next clock; the first fetch is on the 2nd edge after rst_n rises.
- All strobes are Moore outputs decoded combinationally from the state register; no don't-care (x) values are driven. Unused strobes are 0.
- FETCH: mem_req = 1, memread = 1, iord = 0.
  - Hold while mem_ready = 0.
  - On mem_ready = 1, in the same cycle: irwrite = 1, pcwrite = 1, alusrca = 0, alusrcb = 01, aluop = 00, pcsource = 00; then go to DECODE.
  - irwrite/pcwrite are therefore qualified by mem_ready, the only Mealy terms.
- DECODE: alusrca = 0, alusrcb = 11, aluop = 00. Next state by OPCODE:
  - LW/SW -> MEMADR; RTYPE -> EXEC; ADDI -> ADDIEX; BEQ -> BRANCH; J -> JUMP.
  - Any other opcode -> FETCH with illegal set (sticky until reset).
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. LW -> MEMRD, SW -> MEMWR, using the opcode latched in DECODE.
- MEMRD: mem_req = 1, memread = 1, iord = 1. Wait for mem_ready, then go to MEMWB.
- MEMWB: regdist = 0, memtoreg = 1, regwrite = 1; -> FETCH.
- MEMWR: mem_req = 1, memwrite = 1, iord = 1. Wait for mem_ready, then go to FETCH.
- EXEC: alusrca = 1, alusrcb = 00, aluop = 10; -> RWB.
- RWB: regdist = 1, memtoreg = 0, regwrite = 1; -> FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 00; -> ADDIWB.
- ADDIWB: regdist = 0, memtoreg = 0, regwrite = 1; -> FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, aluop = 01, pcwritecond = 1, pcsource = 01; -> FETCH.
- JUMP: pcwrite = 1, pcsource = 10; -> FETCH.
- Cycle counts with zero-wait memory: R = 4, ADDI = 4, LW = 5, SW = 4, BEQ = 3, J = 3.
- Wait counter:
  - Increments each cycle a mem_req state is held with mem_ready = 0.
  - Clears on mem_ready or on a state change.
  - When TIMEOUT != 0 and the counter reaches TIMEOUT: set timeout_err (sticky), abandon the access and go to FETCH with no writes.
  - The counter saturates and never wraps.
- mem_ready is ignored outside mem_req states.
- Async reset mid-instruction returns immediately to IDLE with all strobes 0; no partial writeback completes.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - the state enum constants;
  - the opcode constants;
  - the ALUOP, ALUSRCB and PCSOURCE encodings.
- One sub-module is natural: mips_mem_wait_timer (counter, saturation, timeout compare).

Test Plan:
- Reset then opcode 6'h23 with mem_ready = 1 always -> states IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH; regwrite = 1 and memtoreg = 1 only in MEMWB; 5 cycles per instruction.
- Opcode 6'h00, then 6'h04, then 6'h02 -> 4, 3 and 3 cycle sequences respectively.
  - aluop = 10 in EXEC; aluop = 01 with pcwritecond = 1 in BRANCH; pcsource = 10 with pcwrite = 1 in JUMP.
- SW with mem_ready low for 3 cycles in MEMWR -> memwrite held 4 cycles, timeout_err stays 0, then FETCH.
- TIMEOUT = 15, mem_ready stuck 0 in FETCH -> timeout_err = 1 after 15 wait cycles; FETCH re-entered; irwrite never asserted.
- Opcode 6'h3F -> illegal = 1 after DECODE and return to FETCH; illegal stays 1 through a following valid ADDI (6'h08, ADDIWB regwrite = 1, regdist = 0).
- rst_n pulsed low during MEMRD -> all outputs 0 asynchronously; no MEMWB regwrite; FETCH on the 2nd edge after release.
